plic_gateway: RTL and testbench
===============================

Name: plic_gateway

Overview:
- Per-source interrupt gateway that sits between raw device interrupt lines and the PLIC core's src_i inputs.
- Synchronises asynchronous lines and converts level or edge events into single-cycle requests.
- Enforces at most one outstanding request per source until software completes that source's claim.
- Counts edges that arrive while a request is outstanding and replays them after completion; without it, the core re-latches level sources immediately and loses edges.

Parameters:
- NSOURCES, 32: number of interrupt sources. Source 0 is reserved and never fires.
- SRC_ID_WIDTH, 5: width of completion IDs; must satisfy 2^SRC_ID_WIDTH >= NSOURCES.
- EDGE_CNT_WIDTH, 4: per-source width of the saturating pending-edge counter.
- SYNC_STAGES, 2: flop stages in each input synchroniser (>=2).

Ports:
- clk_i  in  1  system clock (the only clock)
- rst_ni  in  1  asynchronous, active-low reset
- irq_i  in  NSOURCES  raw device interrupt lines, asynchronous to clk_i
- mode_i  in  NSOURCES  per-source trigger mode: 1 = rising edge, 0 = level-high
- enable_i  in  NSOURCES  per-source gateway enable (mirror of the PLIC enable register)
- complete_i  in  1  single-cycle strobe: software completed a claim
- complete_id_i  in  SRC_ID_WIDTH  source ID being completed, qualified by complete_i
- ovf_clr_i  in  1  clears all overflow_o bits
- src_o  out  NSOURCES  single-cycle request pulses to the PLIC core src_i
- inflight_o  out  NSOURCES  high while a source is in FIRE or INFLIGHT
- overflow_o  out  NSOURCES  sticky flag: an edge was lost because the counter was saturated

Behaviour:
- Reset (async assert, sync release):
  - all synchroniser and edge-history flops = 0;
  - all per-source states = IDLE;
  - all edge counters = 0;
  - src_o, inflight_o and overflow_o = 0.
  - Reset mid-operation drops all outstanding requests and counts. A level line still high re-fires after resynchronisation.
- Synchroniser: s[i] is irq_i[i] after SYNC_STAGES flops. rise[i] = s[i] & ~s_prev[i], where s_prev is one more flop.
- Trigger in IDLE:
  - level mode: s[i] == 1;
  - edge mode: rise[i] or cnt[i] != 0.
  - The trigger is qualified by enable_i[i].
- Per-source FSM (i = 1..NSOURCES-1):
  - IDLE: if enable_i[i] and trigger, go to FIRE; otherwise stay.
  - FIRE: go to INFLIGHT unconditionally. Completion strobes seen in FIRE are ignored.
  - INFLIGHT: if complete_i && complete_id_i == i, go to IDLE; otherwise stay.
- Outputs:
  - src_o[i] is registered, equals (state == FIRE), and is exactly one cycle wide.
  - inflight_o[i] = (state != IDLE).
- Source 0: src_o[0], inflight_o[0] and overflow_o[0] are tied to 0.
- Completion:
  - complete_id_i of 0, or >= NSOURCES, is ignored.
  - A completion for a source not in INFLIGHT is ignored.
- Latency:
  - irq_i rising, first sampled at clock edge E: src_o high during the cycle after edge E+SYNC_STAGES.
  - Completion strobe in cycle N: IDLE after edge N+1. Earliest re-fire is src_o high in cycle N+2, giving at least one low cycle between pulses.
- Edge counter, edge mode only:
  - a rise while in FIRE or INFLIGHT increments cnt, saturating at 2^EDGE_CNT_WIDTH-1;
  - a rise at saturation sets overflow_o[i];
  - an IDLE->FIRE transition with no rise that cycle decrements cnt;
  - an IDLE->FIRE transition with a rise and cnt != 0 that cycle leaves cnt unchanged;
  - rises while enable_i[i] = 0 and IDLE are dropped and not counted.
- Mode changes:
  - mode_i = 0 forces cnt[i] to 0 every cycle;
  - a mode change does not disturb FIRE or INFLIGHT and takes effect at the next IDLE evaluation.
- Enable: clearing enable_i[i] while in FIRE or INFLIGHT does not abort; completion is still required.
- Overflow clear: ovf_clr_i clears all overflow bits. A same-cycle set wins for that bit.

Test Plan:
- Level source 3, enabled, irq_i[3] held high (SYNC_STAGES=2) -> src_o[3] pulses once, 3 cycles after the first sampling edge; inflight_o[3]=1. Complete id 3 -> src_o[3] re-pulses 2 cycles later; a held-low line produces no re-pulse.
- Edge source 5: 3 rising edges during INFLIGHT -> cnt=3, no src_o. Then 3 completions of id 5 -> exactly 3 further single-cycle src_o[5] pulses, each following its completion by 2 cycles.
- Edge source 7: 20 rises while INFLIGHT with EDGE_CNT_WIDTH=4 -> cnt saturates at 15 and overflow_o[7]=1. Assert ovf_clr_i together with another saturated rise -> overflow_o[7] remains 1.
- Completion edge cases: complete id 0, id 9 while source 9 is IDLE, and an id equal to a source in FIRE -> no state change anywhere. Sources 2 and 30 triggered in the same cycle -> both pulse in the same cycle.
- Disabled source 4 with edge activity -> no pulses and cnt stays 0. Enable while the line is low -> still nothing. Source 4 in INFLIGHT then enable dropped -> stays INFLIGHT until complete id 4.
- Assert rst_ni low while sources 3 and 5 are INFLIGHT with cnt[5]=2 -> all outputs 0 immediately. After release with irq_i[3] high -> src_o[3] fires again after the sync latency; src_o[5] does not fire.

Source files
------------

// File: rtl/plic_gateway.sv
// Interrupt gateway between raw device lines and the PLIC core: synchronises each line,
// issues one request pulse per claim, and replays edges that arrived while a claim was open.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | no request outstanding; waiting for an enabled trigger
// ST_FIRE     | one-cycle request pulse driven onto src_o
// ST_INFLIGHT | request claimed or pending; waiting for a matching completion
module plic_gateway #(
  parameter int NSOURCES       = 32,
  parameter int SRC_ID_WIDTH   = 5,
  parameter int EDGE_CNT_WIDTH = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NSOURCES-1:0]     irq_i,
  input  logic [NSOURCES-1:0]     mode_i,
  input  logic [NSOURCES-1:0]     enable_i,
  input  logic                    complete_i,
  input  logic [SRC_ID_WIDTH-1:0] complete_id_i,
  input  logic                    ovf_clr_i,
  output logic [NSOURCES-1:0]     src_o,
  output logic [NSOURCES-1:0]     inflight_o,
  output logic [NSOURCES-1:0]     overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_INFLIGHT = 2'd2
  } state_t;

  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < NSOURCES; i++) begin : g_src
    if (i == 0) begin : g_rsvd
      // Source 0 is reserved by the PLIC; its inputs are deliberately ignored.
      logic w_unused_src0;
      assign w_unused_src0 = ^{irq_i[0], mode_i[0], enable_i[0]};
      assign src_o[0]       = 1'b0;
      assign inflight_o[0]  = 1'b0;
      assign overflow_o[0]  = 1'b0;
    end else begin : g_gw
      logic [SYNC_STAGES-1:0]    r_sync;
      logic                      r_prev;
      logic [EDGE_CNT_WIDTH-1:0] r_cnt;
      logic                      r_ovf;
      state_t                    r_state;
      state_t                    w_state_nxt;
      logic                      w_s;
      logic                      w_rise;
      logic                      w_trig;
      logic                      w_cmp_hit;
      logic                      w_go;
      logic                      w_ovf_set;
      logic                      w_src;
      logic                      w_inflight;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_sync <= '0;
          r_prev <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], irq_i[i]};
          r_prev <= r_sync[SYNC_STAGES-1];
        end
      end

      assign w_s       = r_sync[SYNC_STAGES-1];
      assign w_rise    = w_s & ~r_prev;
      assign w_trig    = mode_i[i] ? (w_rise | (r_cnt != '0)) : w_s;
      assign w_cmp_hit = complete_i && (complete_id_i == SRC_ID_WIDTH'(i));
      assign w_go      = (r_state == ST_IDLE) && enable_i[i] && w_trig;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
      end

      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          ST_IDLE:     if (enable_i[i] && w_trig) w_state_nxt = ST_FIRE;
          ST_FIRE:     w_state_nxt = ST_INFLIGHT;
          ST_INFLIGHT: if (w_cmp_hit) w_state_nxt = ST_IDLE;
          default:     w_state_nxt = ST_IDLE;
        endcase
      end

      always_comb begin
        w_src      = (r_state == ST_FIRE);
        w_inflight = (r_state != ST_IDLE);
      end

      // A trigger with a simultaneous rise consumes that rise, so the stored count is kept.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_cnt <= '0;
        end else if (!mode_i[i]) begin
          r_cnt <= '0;
        end else if (r_state != ST_IDLE) begin
          if (w_rise && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
        end else if (w_go && !w_rise) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      assign w_ovf_set = mode_i[i] && (r_state != ST_IDLE) && w_rise && (r_cnt == CNT_MAX);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_ovf <= 1'b0;
        else         r_ovf <= w_ovf_set | (r_ovf & ~ovf_clr_i);
      end

      assign src_o[i]      = w_src;
      assign inflight_o[i] = w_inflight;
      assign overflow_o[i] = r_ovf;
    end
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed scenarios plus a random phase, all checked every cycle
// against a behavioural per-source model (outstanding flag, pulse flag, pending count).
module tb_plic_gateway;
  localparam int NS   = 32;
  localparam int IDW  = 5;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS-1:0]  irq, mode, en;
  logic           cmp;
  logic [IDW-1:0] cmp_id;
  logic           ovf_clr;
  logic [NS-1:0]  src, infl, ovf;

  int checks   = 0;
  int failures = 0;

  plic_gateway #(
    .NSOURCES(NS), .SRC_ID_WIDTH(IDW), .EDGE_CNT_WIDTH(CW), .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .mode_i(mode), .enable_i(en),
    .complete_i(cmp), .complete_id_i(cmp_id), .ovf_clr_i(ovf_clr),
    .src_o(src), .inflight_o(infl), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  // Model: hist[k] = irq vector sampled k+1 edges ago; a source is either free or
  // holding one outstanding request (m_busy), with m_fire marking its pulse cycle.
  logic [NS-1:0] hist [0:SS];
  bit            m_busy [NS];
  bit            m_fire [NS];
  int            m_cnt  [NS];
  bit            m_ovf  [NS];

  always @(posedge clk or negedge rst_n) begin
    bit s, sp, rise, set;
    if (!rst_n) begin
      for (int k = 0; k <= SS; k++) hist[k] = '0;
      for (int i = 0; i < NS; i++) begin
        m_busy[i] = 0; m_fire[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      for (int i = 1; i < NS; i++) begin
        s    = hist[SS-1][i];
        sp   = hist[SS][i];
        rise = s && !sp;
        set  = 0;
        if (m_busy[i]) begin
          if (mode[i] && rise) begin
            if (m_cnt[i] == CMAX) set = 1;
            else m_cnt[i] = m_cnt[i] + 1;
          end
          if (!m_fire[i] && cmp && (int'(cmp_id) == i)) m_busy[i] = 0;
          m_fire[i] = 0;
        end else if (en[i] && (mode[i] ? (rise || m_cnt[i] > 0) : s)) begin
          m_busy[i] = 1;
          m_fire[i] = 1;
          if (mode[i] && !rise) m_cnt[i] = m_cnt[i] - 1;
        end
        if (!mode[i]) m_cnt[i] = 0;
        m_ovf[i] = set || (m_ovf[i] && !ovf_clr);
      end
      for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq;
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic [NS-1:0] e_src, e_infl, e_ovf;
    e_src = '0; e_infl = '0; e_ovf = '0;
    for (int i = 0; i < NS; i++) begin
      e_src[i]  = m_fire[i];
      e_infl[i] = m_busy[i];
      e_ovf[i]  = m_ovf[i];
    end
    chk("src_o", src, e_src);
    chk("inflight_o", infl, e_infl);
    chk("overflow_o", ovf, e_ovf);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic complete(input int id);
    cmp = 1'b1; cmp_id = IDW'(id);
    cyc(1);
    cmp = 1'b0; cmp_id = '0;
  endtask

  task automatic rise_pulse(input int i);
    irq[i] = 1'b1; cyc(3);
    irq[i] = 1'b0; cyc(3);
  endtask

  task automatic wait_src(input int i);
    int n;
    n = 0;
    while (!src[i] && n < 20) begin
      cyc(1);
      n++;
    end
    chk("wait_src", 32'(src[i]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; irq = '0; cmp = 1'b0; cmp_id = '0; ovf_clr = 1'b0;
    mode = '0; mode[4] = 1'b1; mode[5] = 1'b1; mode[7] = 1'b1;
    en = '0; en[2] = 1'b1; en[3] = 1'b1; en[5] = 1'b1; en[7] = 1'b1; en[30] = 1'b1;
    cyc(3);
    chk("reset_src", src, 32'h0);
    chk("reset_infl", infl, 32'h0);
    chk("reset_ovf", ovf, 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Level source 3: pulse in the cycle after the third sampling edge.
    irq[3] = 1'b1;
    cyc(1); chk("lvl3_lat_e0", 32'(src[3]), 32'd0);
    cyc(1); chk("lvl3_lat_e1", 32'(src[3]), 32'd0);
    cyc(1); chk("lvl3_lat_e2", 32'(src[3]), 32'd1);
    cyc(1); chk("lvl3_single", 32'(src[3]), 32'd0);
    chk("lvl3_infl", 32'(infl[3]), 32'd1);
    cyc(2);
    cmp = 1'b1; cmp_id = 5'd3;
    cyc(1); cmp = 1'b0; cmp_id = '0;
    chk("lvl3_idle_after_cmp", 32'(infl[3]), 32'd0);
    cyc(1); chk("lvl3_refire", 32'(src[3]), 32'd1);
    irq[3] = 1'b0;
    cyc(4);
    complete(3);
    cyc(6);
    chk("lvl3_low_no_refire", 32'(infl[3]), 32'd0);

    // Edge source 5: three rises while in flight are replayed after completions.
    rise_pulse(5);
    chk("edge5_infl", 32'(infl[5]), 32'd1);
    repeat (3) rise_pulse(5);
    chk("model_cnt5", 32'(m_cnt[5]), 32'd3);
    for (int r = 0; r < 3; r++) begin
      complete(5);
      cyc(1);
      chk("edge5_replay", 32'(src[5]), 32'd1);
      cyc(2);
    end
    complete(5);
    cyc(5);
    chk("edge5_drained", 32'(infl[5]), 32'd0);

    // Edge source 7: saturate, overflow, clear racing with a new set.
    rise_pulse(7);
    repeat (20) rise_pulse(7);
    chk("model_cnt7_sat", 32'(m_cnt[7]), 32'd15);
    chk("edge7_ovf", 32'(ovf[7]), 32'd1);
    irq[7] = 1'b1;
    cyc(2);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("edge7_set_wins", 32'(ovf[7]), 32'd1);
    irq[7] = 1'b0;
    cyc(3);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("edge7_cleared", 32'(ovf[7]), 32'd0);

    // Completion corner cases.
    complete(0);
    complete(9);
    cyc(2);
    chk("cmp_id0_ignored", 32'(infl[7]), 32'd1);
    chk("cmp_idle9_ignored", 32'(infl[9]), 32'd0);
    irq[2] = 1'b1; irq[30] = 1'b1;
    wait_src(2);
    chk("same_cycle_30", 32'(src[30]), 32'd1);
    complete(2);
    cyc(3);
    chk("cmp_in_fire_ignored", 32'(infl[2]), 32'd1);
    irq[2] = 1'b0; irq[30] = 1'b0;
    cyc(3);
    complete(2);
    complete(30);
    cyc(3);

    // Disabled edge source 4.
    repeat (3) rise_pulse(4);
    chk("dis4_no_fire", 32'(infl[4]), 32'd0);
    chk("model_cnt4", 32'(m_cnt[4]), 32'd0);
    en[4] = 1'b1;
    cyc(5);
    chk("en4_low_line", 32'(infl[4]), 32'd0);
    rise_pulse(4);
    chk("en4_fired", 32'(infl[4]), 32'd1);
    en[4] = 1'b0;
    cyc(5);
    chk("dis4_keeps_infl", 32'(infl[4]), 32'd1);
    complete(4);
    cyc(2);
    chk("dis4_completed", 32'(infl[4]), 32'd0);

    // Reset while sources 3 and 5 are outstanding.
    irq[3] = 1'b1;
    cyc(6);
    rise_pulse(5);
    repeat (2) rise_pulse(5);
    chk("model_cnt5_pre_rst", 32'(m_cnt[5]), 32'd2);
    chk("pre_rst_infl3", 32'(infl[3]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_src", src, 32'h0);
    chk("rst_async_infl", infl, 32'h0);
    chk("rst_async_ovf", ovf, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_lvl3", 32'(src[3]), 32'd1);
    chk("post_rst_edge5", 32'(src[5]), 32'd0);
    cyc(10);
    chk("post_rst_no5", 32'(infl[5]), 32'd0);

    // Random phase.
    en = 32'hFFFF_FFFE;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 1; i < NS; i++) begin
        if ($urandom_range(0, 15) == 0)  irq[i]  = ~irq[i];
        if ($urandom_range(0, 199) == 0) mode[i] = ~mode[i];
        if ($urandom_range(0, 99) == 0)  en[i]   = ~en[i];
      end
      cmp     = ($urandom_range(0, 5) == 0);
      cmp_id  = ($urandom_range(0, 1) == 0) ? IDW'($urandom_range(0, 7)) : IDW'($urandom_range(0, 31));
      ovf_clr = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    cmp = 1'b0; ovf_clr = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
